// File: rtl/flow_route_sequencer.sv
// flow_route_sequencer: clocked stage-by-stage flow-switch route sequencer.
// It opens stage switches cumulatively with settle and dwell timing, then flushes to the outlet.
`default_nettype none
module flow_route_sequencer #(
  parameter int NUM_STAGES        = 5,
  parameter int DEVICES_PER_STAGE = 4,
  parameter int SEL_W             = 2,
  parameter int DWELL_W           = 8,
  parameter int SETTLE_CYCLES     = 3,
  parameter int FLUSH_CYCLES      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [NUM_STAGES*SEL_W-1:0]   cmd_sel,
  input  logic [NUM_STAGES-1:0]         cmd_skip,
  input  logic [DWELL_W-1:0]            cmd_dwell,
  input  logic                          abort,
  output logic [NUM_STAGES-1:0]         sw_en,
  output logic [NUM_STAGES*SEL_W-1:0]   sw_sel,
  output logic                          out_valve,
  output logic [$clog2(NUM_STAGES+1)-1:0] cur_stage,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic                          err
);
  localparam int STG_W = $clog2(NUM_STAGES+1);
  localparam int CW_S  = $clog2(SETTLE_CYCLES+1);
  localparam int CW_F  = $clog2(FLUSH_CYCLES+1);
  localparam int CW_SF = (CW_S > CW_F) ? CW_S : CW_F;
  localparam int CNT_W = (DWELL_W > CW_SF) ? DWELL_W : CW_SF;

  typedef enum logic [2:0] {IDLE, SETTLE, DWELL, SKIP, FLUSH, DONE} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [NUM_STAGES*SEL_W-1:0]   sel_q;
  logic [NUM_STAGES-1:0]         skip_q;
  logic [DWELL_W-1:0]            dwell_q;

  logic                          cmd_ok;
  logic                          enter;
  logic                          enter_skip;
  logic [STG_W-1:0]              enter_k;
  logic [NUM_STAGES*SEL_W-1:0]   enter_sel_vec;
  logic [NUM_STAGES-1:0]         enter_skip_vec;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == SETTLE) || (state == DWELL) || (state == SKIP) || (state == FLUSH);

  // Stage entry is shared by acceptance (stage 0 from the live command) and stage completion.
  always_comb begin
    cmd_ok = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (!cmd_skip[i] && (int'(cmd_sel[i*SEL_W +: SEL_W]) >= DEVICES_PER_STAGE))
        cmd_ok = 1'b0;
    end
    enter          = 1'b0;
    enter_k        = cur_stage + STG_W'(1);
    enter_sel_vec  = sel_q;
    enter_skip_vec = skip_q;
    case (state)
      IDLE: begin
        enter          = cmd_valid && cmd_ok;
        enter_k        = '0;
        enter_sel_vec  = cmd_sel;
        enter_skip_vec = cmd_skip;
      end
      SETTLE:  enter = (cnt == '0) && (dwell_q == '0);
      DWELL:   enter = (cnt == '0);
      SKIP:    enter = 1'b1;
      default: enter = 1'b0;
    endcase
    enter_skip = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i == int'(enter_k)) enter_skip = enter_skip_vec[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_q     <= '0;
      skip_q    <= '0;
      dwell_q   <= '0;
      sw_en     <= '0;
      sw_sel    <= '0;
      out_valve <= 1'b0;
      cur_stage <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      if (busy && abort) begin
        state     <= IDLE;
        cnt       <= '0;
        sw_en     <= '0;
        sw_sel    <= '0;
        out_valve <= 1'b0;
        cur_stage <= '0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              if (cmd_ok) begin
                sel_q   <= cmd_sel;
                skip_q  <= cmd_skip;
                dwell_q <= cmd_dwell;
              end else begin
                err <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (dwell_q != '0) begin
              state <= DWELL;
              cnt   <= CNT_W'(dwell_q) - CNT_W'(1);
            end
          end
          DWELL: begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
          end
          FLUSH: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              state     <= DONE;
              out_valve <= 1'b0;
              sw_en     <= '0;
              sw_sel    <= '0;
              done      <= 1'b1;
            end
          end
          DONE: begin
            state     <= IDLE;
            cur_stage <= '0;
          end
          default: state <= IDLE;
        endcase

        if (enter) begin
          cur_stage <= enter_k;
          if (enter_k == STG_W'(NUM_STAGES)) begin
            state     <= FLUSH;
            out_valve <= 1'b1;
            cnt       <= CNT_W'(FLUSH_CYCLES - 1);
          end else if (enter_skip) begin
            state <= SKIP;
          end else begin
            state <= SETTLE;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (i == int'(enter_k)) begin
                sw_en[i]                   <= 1'b1;
                sw_sel[i*SEL_W +: SEL_W]   <= enter_sel_vec[i*SEL_W +: SEL_W];
              end
            end
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_flow_route_sequencer.sv
// Testbench for flow_route_sequencer: per-cycle comparison against a route timeline model.
`default_nettype none
module tb_flow_route_sequencer;
  localparam int NS = 5, SW = 2, DW = 8, SETTLE = 3, FLUSH = 4;

  typedef struct packed {
    logic [NS-1:0]    en;
    logic [NS*SW-1:0] sel;
    logic             valve;
    logic [2:0]       stage;
    logic             busy;
    logic             done;
    logic             ready;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [NS*SW-1:0] cmd_sel = '0;
  logic [NS-1:0]    cmd_skip = '0;
  logic [DW-1:0]    cmd_dwell = '0;

  logic cmd_ready, out_valve, busy, done, aborted, err;
  logic [NS-1:0] sw_en;
  logic [NS*SW-1:0] sw_sel;
  logic [2:0] cur_stage;
  logic e3_ready, e3_valve, e3_busy, e3_done, e3_aborted, e3_err;
  logic [NS-1:0] e3_sw_en;
  logic [NS*SW-1:0] e3_sw_sel;
  logic [2:0] e3_stage;

  int checks = 0, errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  flow_route_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_skip(cmd_skip), .cmd_dwell(cmd_dwell), .abort(abort), .sw_en(sw_en), .sw_sel(sw_sel),
    .out_valve(out_valve), .cur_stage(cur_stage), .busy(busy), .done(done), .aborted(aborted), .err(err));

  flow_route_sequencer #(.DEVICES_PER_STAGE(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(e3_ready), .cmd_sel(cmd_sel),
    .cmd_skip(cmd_skip), .cmd_dwell(cmd_dwell), .abort(abort), .sw_en(e3_sw_en), .sw_sel(e3_sw_sel),
    .out_valve(e3_valve), .cur_stage(e3_stage), .busy(e3_busy), .done(e3_done), .aborted(e3_aborted), .err(e3_err));

  function automatic exp_t mk(logic [NS-1:0] en, logic [NS*SW-1:0] sv, logic v, int st, logic b, logic d, logic r);
    exp_t e;
    e.en = en; e.sel = sv; e.valve = v; e.stage = 3'(st); e.busy = b; e.done = d; e.ready = r;
    return e;
  endfunction

  // Expected outputs for cycles 1.. after acceptance, ending with the first IDLE cycle.
  task automatic build(input logic [NS*SW-1:0] s, input logic [NS-1:0] k, input logic [DW-1:0] d);
    logic [NS-1:0] en;
    logic [NS*SW-1:0] sv;
    q.delete();
    en = '0; sv = '0;
    for (int i = 0; i < NS; i++) begin
      if (k[i]) q.push_back(mk(en, sv, 1'b0, i, 1'b1, 1'b0, 1'b0));
      else begin
        en[i] = 1'b1;
        sv[i*SW +: SW] = s[i*SW +: SW];
        for (int j = 0; j < SETTLE + int'(d); j++) q.push_back(mk(en, sv, 1'b0, i, 1'b1, 1'b0, 1'b0));
      end
    end
    for (int j = 0; j < FLUSH; j++) q.push_back(mk(en, sv, 1'b1, NS, 1'b1, 1'b0, 1'b0));
    q.push_back(mk('0, '0, 1'b0, NS, 1'b0, 1'b1, 1'b0));
    q.push_back(mk('0, '0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
  endtask

  // Called at a falling edge; drives the command in that cycle (cycle 0).
  task automatic run_route(input logic [NS*SW-1:0] s, input logic [NS-1:0] k, input logic [DW-1:0] d,
                           input int abort_at, input string nm, output int done_cyc);
    exp_t e;
    int ab;
    logic [13:0] got, want;
    build(s, k, d);
    ab = (abort_at > q.size() - 2) ? q.size() - 2 : abort_at;
    done_cyc = -1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got %b exp 1", nm, cmd_ready); end
    cmd_valid = 1'b1; cmd_sel = s; cmd_skip = k; cmd_dwell = d; abort = (ab == 0);
    for (int c = 1; c <= q.size(); c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_sel = NS*SW'($urandom); cmd_skip = NS'($urandom); cmd_dwell = DW'($urandom);
      end
      e = q[c-1];
      if (done === 1'b1) done_cyc = c;
      got  = {sw_en, out_valve, cur_stage, busy, done, cmd_ready, aborted, err};
      want = {e.en, e.valve, e.stage, e.busy, e.done, e.ready, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin errors++; $display("FAIL %s cyc%0d en/valve/stage/busy/done/ready/abt/err got %b exp %b", nm, c, got, want); end
      if (e.busy) begin
        checks++;
        if (sw_sel !== e.sel) begin errors++; $display("FAIL %s cyc%0d sw_sel got %b exp %b", nm, c, sw_sel, e.sel); end
      end
      if (c == ab) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({sw_en, sw_sel, out_valve, busy, done, aborted, cmd_ready} !== {15'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL %s abort_cyc%0d en=%b sel=%b valve=%b busy=%b done=%b aborted=%b ready=%b exp aborted=1 ready=1 rest 0",
                   nm, c + 1, sw_en, sw_sel, out_valve, busy, done, aborted, cmd_ready);
        end
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({cmd_ready, busy, sw_en, sw_sel, out_valve, cur_stage, done, aborted, err} !== {1'b1, 23'b0}) begin
      errors++;
      $display("FAIL reset got ready=%b busy=%b en=%b sel=%b valve=%b stage=%0d done=%b abt=%b err=%b exp ready=1 rest 0",
               cmd_ready, busy, sw_en, sw_sel, out_valve, cur_stage, done, aborted, err);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL reset_release ready/busy got %b exp 10", {cmd_ready, busy}); end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(cmd_ready === 1'b1 && e3_ready === 1'b1) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL %s idle_timeout got busy exp idle within 100 cycles", nm); end
  endtask

  task automatic test_err;
    cmd_valid = 1'b1; cmd_sel = {2'd0, 2'd0, 2'd3, 2'd1, 2'd2}; cmd_skip = '0; cmd_dwell = 8'd1;
    @(negedge clk); cmd_valid = 1'b0;
    checks++;
    if ({e3_err, e3_ready, e3_busy, e3_sw_en} !== {1'b1, 1'b1, 1'b0, 5'b0}) begin
      errors++; $display("FAIL err_pulse err/ready/busy/en got %b exp 1100000", {e3_err, e3_ready, e3_busy, e3_sw_en});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err_default_accept ready got %b exp 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if ({e3_err, e3_ready} !== 2'b01) begin errors++; $display("FAIL err_one_cycle err/ready got %b exp 01", {e3_err, e3_ready}); end
    wait_idle("err_first");
    cmd_valid = 1'b1; cmd_skip = 5'b00100;
    @(negedge clk); cmd_valid = 1'b0;
    checks++;
    if ({e3_err, e3_ready, e3_sw_en} !== {1'b0, 1'b0, 5'b00001}) begin
      errors++; $display("FAIL err_skipped_accept err/ready/en got %b exp 0000001", {e3_err, e3_ready, e3_sw_en});
    end
    wait_idle("err_second");
  endtask

  task automatic test_basic;
    int dc;
    run_route(10'b11_10_01_00_11, 5'b00000, 8'd2, -1, "basic", dc);
    checks++;
    if (dc !== 30) begin errors++; $display("FAIL basic_done_cycle got %0d exp 30", dc); end
  endtask

  task automatic test_skip;
    int dc;
    run_route(10'b01_10_11_00_10, 5'b01010, 8'd2, -1, "skip", dc);
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL skip_done_cycle got %0d exp 22", dc); end
    run_route(10'b10_01_11_10_01, 5'b11111, 8'd3, -1, "all_skip", dc);
    checks++;
    if (dc !== 10) begin errors++; $display("FAIL all_skip_done_cycle got %0d exp 10", dc); end
  endtask

  task automatic test_dwell0;
    int dc;
    run_route(10'b00_11_01_10_01, 5'b00000, 8'd0, -1, "dwell0", dc);
    checks++;
    if (dc !== 20) begin errors++; $display("FAIL dwell0_done_cycle got %0d exp 20", dc); end
  endtask

  task automatic test_abort;
    int dc;
    run_route(10'b11_10_01_00_11, 5'b00000, 8'd2, 8, "abort", dc);
    checks++;
    if (dc !== -1) begin errors++; $display("FAIL abort_no_done got done at %0d exp none", dc); end
    run_route(10'b01_01_10_10_11, 5'b00100, 8'd1, -1, "after_abort", dc);
  endtask

  task automatic test_back_to_back;
    int dc, ab;
    for (int r = 0; r < 12; r++) begin
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_route(NS*SW'($urandom), NS'($urandom), DW'($urandom_range(0, 4)), ab, $sformatf("rand%0d", r), dc);
    end
  endtask

  task automatic test_async_rst;
    cmd_valid = 1'b1; cmd_sel = 10'b11_10_01_00_11; cmd_skip = '0; cmd_dwell = 8'd2;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if ({sw_en, busy} !== {5'b00111, 1'b1}) begin errors++; $display("FAIL rst_pre en/busy got %b exp 001111", {sw_en, busy}); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({sw_en, sw_sel, out_valve, busy, done, aborted, cmd_ready} !== {15'b0, 4'b0, 1'b1}) begin
      errors++; $display("FAIL rst_immediate en=%b sel=%b valve=%b busy=%b done=%b abt=%b ready=%b exp ready=1 rest 0",
                         sw_en, sw_sel, out_valve, busy, done, aborted, cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({done, aborted} !== 2'b00) begin errors++; $display("FAIL rst_no_pulse done/aborted got %b exp 00", {done, aborted}); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, aborted} !== 4'b1000) begin
      errors++; $display("FAIL rst_release ready/busy/done/aborted got %b exp 1000", {cmd_ready, busy, done, aborted});
    end
  endtask

  initial begin
    test_reset;
    test_err;
    test_basic;
    test_skip;
    test_dwell0;
    test_abort;
    test_back_to_back;
    test_async_rst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
